// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one single-port synchronous data memory between the core load/store
// unit and an external master. At most one access is granted per cycle.
// Arbitration is round-robin with a bounded burst. Read data returns one
// cycle after acceptance, passed straight through from the memory output.
module dmem_port_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                core_valid,
   output logic                core_ready,
   input  logic                core_we,
   input  logic [ADDR_W-1:0]   core_addr,
   input  logic [DATA_W-1:0]   core_wdata,
   input  logic [DATA_W/8-1:0] core_wstrb,
   output logic                core_rsp_valid,
   output logic [DATA_W-1:0]   core_rdata,

   input  logic                ext_valid,
   output logic                ext_ready,
   input  logic                ext_we,
   input  logic [ADDR_W-1:0]   ext_addr,
   input  logic [DATA_W-1:0]   ext_wdata,
   input  logic [DATA_W/8-1:0] ext_wstrb,
   output logic                ext_rsp_valid,
   output logic [DATA_W-1:0]   ext_rdata,

   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(MAX_BURST + 1);

   localparam logic [0:0] SIDE_CORE = 1'b0;
   localparam logic [0:0] SIDE_EXT  = 1'b1;

   logic [0:0]       r_rr_ptr;
   logic [CNT_W-1:0] r_burst_cnt;
   logic             r_rsp_pending;
   logic [0:0]       r_rsp_owner;
   logic             r_rsp_is_read;

   logic             w_ptr_capped;
   logic             w_grant_core;
   logic             w_grant_ext;
   logic             w_accept;
   logic [0:0]       w_win_side;
   logic             w_win_we;

   // The pointer side has used up its burst allowance.
   assign w_ptr_capped = (r_burst_cnt == CNT_W'(MAX_BURST));

   // Grant selection; nothing is granted while reset is asserted so that
   // ready and the memory strobes drop immediately with rst_n.
   always_comb begin
      w_grant_core = 1'b0;
      w_grant_ext  = 1'b0;
      if (rst_n) begin
         if (core_valid && !ext_valid) begin
            w_grant_core = 1'b1;
         end else if (ext_valid && !core_valid) begin
            w_grant_ext = 1'b1;
         end else if (core_valid && ext_valid) begin
            // Pointer side wins unless capped, in which case the other side does.
            if ((r_rr_ptr == SIDE_EXT) ^ w_ptr_capped) begin
               w_grant_ext = 1'b1;
            end else begin
               w_grant_core = 1'b1;
            end
         end
      end
   end

   assign w_accept   = w_grant_core | w_grant_ext;
   assign w_win_side = w_grant_ext ? SIDE_EXT : SIDE_CORE;
   assign w_win_we   = w_grant_ext ? ext_we : core_we;

   assign core_ready = w_grant_core;
   assign ext_ready  = w_grant_ext;

   // Memory request mux driven from the winning requester.
   always_comb begin
      mem_en    = w_accept;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_grant_ext) begin
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
         mem_we    = ext_we ? ext_wstrb : {STRB_W{1'b0}};
      end else if (w_grant_core) begin
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
         mem_we    = core_we ? core_wstrb : {STRB_W{1'b0}};
      end
   end

   // Round-robin pointer and burst length tracking; an idle cycle clears the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= SIDE_CORE;
         r_burst_cnt <= '0;
      end else if (w_accept) begin
         if (w_win_side == r_rr_ptr) begin
            if (!w_ptr_capped) begin
               r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
         end else begin
            r_burst_cnt <= CNT_W'(1);
            r_rr_ptr    <= w_win_side;
         end
      end else begin
         r_burst_cnt <= '0;
      end
   end

   // Response bookkeeping for the access accepted in the previous cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_pending <= 1'b0;
         r_rsp_owner   <= SIDE_CORE;
         r_rsp_is_read <= 1'b0;
      end else begin
         r_rsp_pending <= w_accept;
         if (w_accept) begin
            r_rsp_owner   <= w_win_side;
            r_rsp_is_read <= !w_win_we;
         end
      end
   end

   // Route the single response to its owner; write responses carry zero data.
   always_comb begin
      core_rsp_valid = r_rsp_pending && (r_rsp_owner == SIDE_CORE);
      ext_rsp_valid  = r_rsp_pending && (r_rsp_owner == SIDE_EXT);
      core_rdata     = (core_rsp_valid && r_rsp_is_read) ? mem_rdata : '0;
      ext_rdata      = (ext_rsp_valid  && r_rsp_is_read) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a read-first BRAM model and a
// response scoreboard checked by an independent monitor.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        core_valid = 1'b0, core_we = 1'b0;
   logic [9:0]  core_addr = '0;
   logic [31:0] core_wdata = '0;
   logic [3:0]  core_wstrb = '0;
   logic        core_ready, core_rsp_valid;
   logic [31:0] core_rdata;

   logic        ext_valid = 1'b0, ext_we = 1'b0;
   logic [9:0]  ext_addr = '0;
   logic [31:0] ext_wdata = '0;
   logic [3:0]  ext_wstrb = '0;
   logic        ext_ready, ext_rsp_valid;
   logic [31:0] ext_rdata;

   logic        mem_en;
   logic [3:0]  mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic [31:0] mem [0:1023];

   typedef struct {
      int          owner;
      logic [31:0] data;
      int          due;
   } rsp_t;

   rsp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   dmem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_wstrb(core_wstrb),
      .core_rsp_valid(core_rsp_valid), .core_rdata(core_rdata),
      .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_wstrb(ext_wstrb),
      .ext_rsp_valid(ext_rsp_valid), .ext_rdata(ext_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Read-first synchronous BRAM model
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= mem[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   // Response monitor
   always @(negedge clk) begin
      rsp_t e;
      int   act_owner;
      if (sb.size() > 0 && sb[0].due < cyc) begin
         n_tests++; n_fail++;
         $display("FAIL rsp_missing: cycle %0d, expected owner %0d due %0d not seen", cyc, sb[0].owner, sb[0].due);
         void'(sb.pop_front());
      end
      if (core_rsp_valid || ext_rsp_valid) begin
         n_tests++;
         act_owner = core_rsp_valid ? 1 : 2;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: cycle %0d owner %0d with no outstanding access", cyc, act_owner);
         end else begin
            e = sb.pop_front();
            if (core_rsp_valid !== (e.owner == 1) || ext_rsp_valid !== (e.owner == 2) || e.due != cyc ||
                (e.owner == 1 && (core_rdata !== e.data || ext_rdata !== 32'h0)) ||
                (e.owner == 2 && (ext_rdata !== e.data || core_rdata !== 32'h0))) begin
               n_fail++;
               $display("FAIL rsp: cycle %0d got core_v=%0b core_d=%h ext_v=%0b ext_d=%h, expected owner %0d data %h at cycle %0d",
                        cyc, core_rsp_valid, core_rdata, ext_rsp_valid, ext_rdata, e.owner, e.data, e.due);
            end
         end
      end else begin
         n_tests++;
         if (core_rdata !== 32'h0 || ext_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_rdata: cycle %0d core_rdata=%h ext_rdata=%h, expected 0", cyc, core_rdata, ext_rdata);
         end
      end
   end

   task automatic set_core(input logic v, input logic we, input logic [9:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      core_valid = v; core_we = we; core_addr = a; core_wdata = d; core_wstrb = s;
   endtask

   task automatic set_ext(input logic v, input logic we, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      ext_valid = v; ext_we = we; ext_addr = a; ext_wdata = d; ext_wstrb = s;
   endtask

   // g: 0 none, 1 core, 2 ext. Checks grant and memory bus, queues the response.
   task automatic chk(input int g, input logic [31:0] exp_d, input string name);
      logic [9:0]  ea;
      logic [31:0] ed;
      logic [3:0]  ew;
      @(negedge clk);
      n_tests++;
      if (core_ready !== (g == 1) || ext_ready !== (g == 2) || mem_en !== (g != 0)) begin
         n_fail++;
         $display("FAIL %s grant: cycle %0d core_ready=%0b ext_ready=%0b mem_en=%0b, expected grant %0d",
                  name, cyc, core_ready, ext_ready, mem_en, g);
      end
      if (g != 0) begin
         ea = (g == 1) ? core_addr  : ext_addr;
         ed = (g == 1) ? core_wdata : ext_wdata;
         ew = (g == 1) ? (core_we ? core_wstrb : 4'h0) : (ext_we ? ext_wstrb : 4'h0);
         n_tests++;
         if (mem_addr !== ea || mem_we !== ew || (ew != 4'h0 && mem_wdata !== ed)) begin
            n_fail++;
            $display("FAIL %s mem_bus: addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                     name, mem_addr, mem_we, mem_wdata, ea, ew, ed);
         end
         sb.push_back('{owner: g, data: exp_d, due: cyc + 1});
      end else begin
         n_tests++;
         if (mem_we !== 4'h0) begin
            n_fail++;
            $display("FAIL %s idle_we: mem_we=%b, expected 0000", name, mem_we);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string name);
      n_tests++;
      if (core_ready !== 1'b0 || ext_ready !== 1'b0 || core_rsp_valid !== 1'b0 || ext_rsp_valid !== 1'b0 ||
          mem_en !== 1'b0 || mem_we !== 4'h0 || core_rdata !== 32'h0 || ext_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL %s: rdy=%0b/%0b rsp=%0b/%0b en=%0b we=%b rdata=%h/%h, expected all 0",
                  name, core_ready, ext_ready, core_rsp_valid, ext_rsp_valid, mem_en, mem_we, core_rdata, ext_rdata);
      end
   endtask

   int g3 [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
   bit cv5 [14] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
   bit ev5 [14] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
   int g5  [14] = '{1, 1, 1, 0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1};

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h010] = 32'hDEADBEEF;
      mem[10'h001] = 32'h1111_0001;
      mem[10'h002] = 32'h2222_0002;
      mem[10'h003] = 32'h3333_0003;
      mem[10'h020] = 32'hC0C0_0020;
      mem[10'h030] = 32'hE0E0_0030;
      mem[10'h3FF] = 32'hAABB_CCDD;

      // Reset state with both requesters asserting valid
      set_core(1, 0, 10'h010, 0, 0);
      set_ext(1, 0, 10'h030, 0, 0);
      @(negedge clk);
      chk_all_zero("reset_state");
      @(posedge clk); #1;
      set_core(0, 0, 0, 0, 0);
      set_ext(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      chk(0, 0, "post_reset_idle");

      // Core-only read
      set_core(1, 0, 10'h010, 0, 0);
      chk(1, 32'hDEADBEEF, "core_read");
      set_core(0, 0, 0, 0, 0);
      chk(0, 0, "idle_a");

      // Ext partial write then readback
      set_ext(1, 1, 10'h3FF, 32'h11223344, 4'b0101);
      chk(2, 32'h0, "ext_write");
      set_ext(1, 0, 10'h3FF, 0, 0);
      chk(2, 32'hAA22CC44, "ext_readback");
      set_ext(0, 0, 0, 0, 0);
      chk(0, 0, "idle_b");

      // Back-to-back core reads
      set_core(1, 0, 10'h001, 0, 0); chk(1, 32'h1111_0001, "b2b_1");
      set_core(1, 0, 10'h002, 0, 0); chk(1, 32'h2222_0002, "b2b_2");
      set_core(1, 0, 10'h003, 0, 0); chk(1, 32'h3333_0003, "b2b_3");
      set_core(0, 0, 0, 0, 0);
      chk(0, 0, "idle_c");

      // Reset while a read response is pending
      set_core(1, 0, 10'h010, 0, 0);
      @(negedge clk);
      n_tests++;
      if (core_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_accept: core_ready=%0b, expected 1", core_ready);
      end
      @(posedge clk); #1;
      set_core(0, 0, 0, 0, 0);
      n_tests++;
      if (core_rsp_valid !== 1'b1 || core_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL midrst_pending: core_rsp_valid=%0b core_rdata=%h, expected 1 DEADBEEF", core_rsp_valid, core_rdata);
      end
      set_core(1, 0, 10'h010, 0, 0);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst_outputs");
      @(posedge clk); @(posedge clk); #1;
      set_core(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (core_rsp_valid !== 1'b0 || ext_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_rsp: cycle %0d core_rsp_valid=%0b ext_rsp_valid=%0b, expected 0", cyc, core_rsp_valid, ext_rsp_valid);
         end
      end
      @(posedge clk); #1;

      // Both requesters continuously valid
      for (int i = 0; i < 10; i++) begin
         set_core(1, 0, 10'h020, 0, 0);
         set_ext(1, 0, 10'h030, 0, 0);
         chk(g3[i], (g3[i] == 1) ? 32'hC0C0_0020 : 32'hE0E0_0030, "rr_burst");
      end
      set_core(0, 0, 0, 0, 0);
      set_ext(0, 0, 0, 0, 0);
      chk(0, 0, "idle_d");

      // Gaps: idle cycle clears the burst run, ext keeps requesting
      for (int i = 0; i < 14; i++) begin
         set_core(cv5[i], 0, 10'h020, 0, 0);
         set_ext(ev5[i], 0, 10'h030, 0, 0);
         chk(g5[i], (g5[i] == 1) ? 32'hC0C0_0020 : 32'hE0E0_0030, "gap_burst");
      end
      set_core(0, 0, 0, 0, 0);
      set_ext(0, 0, 0, 0, 0);
      chk(0, 0, "idle_e");
      chk(0, 0, "idle_f");

      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
